// File: rtl/rom_read_arbiter_if.sv
// Request/response bundle between the two pixel requesters, the image ROM and rom_read_arbiter.
interface rom_read_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;

    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic              busy;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output rom_address, busy
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  rom_address, busy
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter for the single-port image ROM with a latency-matched tag pipeline.
// Round-robin by default; define ROM_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module rom_read_arbiter #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ROM_LATENCY = 2
) (
    input logic               clock,
    input logic               reset,
    rom_read_arbiter_if.slave bus
);
    localparam int unsigned LastStage = ROM_LATENCY - 1;

    logic                   grant0;
    logic                   grant1;
    logic                   accept;
    logic [ADDR_W-1:0]      addr_mux;
    logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
    logic [ROM_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [ROM_LATENCY-1:0] tag_port_q, tag_port_d;
    logic [DATA_W-1:0]      rsp0_data_q, rsp1_data_q;
    logic                   final_valid;
    logic                   final_port;
    logic                   rsp0_valid;
    logic                   rsp1_valid;

`ifndef ROM_ARB_FIXED_PRIO_EN
    logic last_grant_q, last_grant_d;
`endif

    // Arbitration: ready is purely combinational so an accept is possible every cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
`endif
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        addr_mux    = last_addr_q;
        last_addr_d = last_addr_q;
        if (accept) begin
            addr_mux    = grant1 ? bus.req1_addr : bus.req0_addr;
            last_addr_d = addr_mux;
        end
    end

    assign bus.rom_address = addr_mux;

`ifndef ROM_ARB_FIXED_PRIO_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant1;
        end
    end
`endif

    // Stage 0 takes this cycle's accept; the last stage lines up with valid rom_q.
    always_comb begin
        tag_valid_d    = tag_valid_q << 1;
        tag_port_d     = tag_port_q << 1;
        tag_valid_d[0] = accept;
        tag_port_d[0]  = grant1;
    end

    // Tags left over from before a reset are masked while reset is still high.
    assign final_valid = tag_valid_q[LastStage] && !reset;
    assign final_port  = tag_port_q[LastStage];
    assign rsp0_valid  = final_valid && !final_port;
    assign rsp1_valid  = final_valid && final_port;

    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp0_data  = rsp0_valid ? bus.rom_q : rsp0_data_q;
    assign bus.rsp1_data  = rsp1_valid ? bus.rom_q : rsp1_data_q;
    assign bus.busy       = |tag_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_addr_q <= '0;
            tag_valid_q <= '0;
            tag_port_q  <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            if (rsp0_valid) begin
                rsp0_data_q <= bus.rom_q;
            end
            if (rsp1_valid) begin
                rsp1_data_q <= bus.rom_q;
            end
        end
    end

`ifndef ROM_ARB_FIXED_PRIO_EN
    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: ROM_LATENCY=2 and ROM_LATENCY=1 instances share directed stimulus
// and are checked every cycle against a queue-based model plus literal expectations.
module tb_rom_read_arbiter;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          v0, v1;
    logic [AW-1:0] a0, a1;

    always #5 clock = ~clock;

    rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();
    rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if2.req0_valid = v0;
    assign if2.req0_addr  = a0;
    assign if2.req1_valid = v1;
    assign if2.req1_addr  = a1;
    assign if1.req0_valid = v0;
    assign if1.req0_addr  = a0;
    assign if1.req1_valid = v1;
    assign if1.req1_addr  = a1;

    rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(2)) dut2 (
        .clock(clock),
        .reset(reset),
        .bus  (if2.slave)
    );

    rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) dut1 (
        .clock(clock),
        .reset(reset),
        .bus  (if1.slave)
    );

    // ROM models: registered read of ROM_LATENCY stages, q = address[7:0] ^ 8'hA5.
    logic [AW-1:0] rom2_s0, rom2_s1, rom1_s0;
    always @(posedge clock) begin
        rom2_s0 <= if2.rom_address;
        rom2_s1 <= rom2_s0;
        rom1_s0 <= if1.rom_address;
    end
    assign if2.rom_q = rom2_s1[7:0] ^ 8'hA5;
    assign if1.rom_q = rom1_s0[7:0] ^ 8'hA5;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } item_t;

    item_t         mq[2][$];
    logic [7:0]    hold_m[2][2];
    logic          lg_m;
    logic [AW-1:0] la_m;
    int            cyc_n;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input int lat, input logic e_r0, input logic e_r1,
                              input logic [AW-1:0] e_addr, input logic r0, input logic r1,
                              input logic [AW-1:0] addr, input logic bsy,
                              input logic rv0, input logic [7:0] rd0,
                              input logic rv1, input logic [7:0] rd1);
        logic       ev0, ev1, e_busy;
        logic [7:0] ed0, ed1;
        item_t      it;
        string      p;
        p      = $sformatf("L%0d@%0d", lat, cyc_n);
        ev0    = 1'b0;
        ev1    = 1'b0;
        ed0    = hold_m[i][0];
        ed1    = hold_m[i][1];
        e_busy = mq[i].size() != 0;
        if (e_busy && mq[i][0].due == cyc_n) begin
            it = mq[i].pop_front();
            if (!reset) begin
                if (it.port == 0) begin
                    ev0 = 1'b1;
                    ed0 = it.data;
                end else begin
                    ev1 = 1'b1;
                    ed1 = it.data;
                end
            end
        end
        chk({p, " req0_ready"}, 32'(r0), 32'(e_r0));
        chk({p, " req1_ready"}, 32'(r1), 32'(e_r1));
        chk({p, " rom_address"}, 32'(addr), 32'(e_addr));
        chk({p, " busy"}, 32'(bsy), 32'(e_busy));
        chk({p, " rsp0_valid"}, 32'(rv0), 32'(ev0));
        chk({p, " rsp1_valid"}, 32'(rv1), 32'(ev1));
        chk({p, " rsp0_data"}, 32'(rd0), 32'(ed0));
        chk({p, " rsp1_data"}, 32'(rd1), 32'(ed1));
        hold_m[i][0] = ed0;
        hold_m[i][1] = ed1;
        if (e_r0 || e_r1) begin
            it.port = e_r1 ? 1 : 0;
            it.data = e_addr[7:0] ^ 8'hA5;
            it.due  = cyc_n + lat;
            mq[i].push_back(it);
        end
    endtask

    task automatic model_cycle();
        logic          e_r0, e_r1;
        logic [AW-1:0] e_addr;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!reset) begin
            if (v0 && v1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                e_r0 = 1'b1;
`else
                e_r0 = (lg_m == 1'b1);
                e_r1 = (lg_m == 1'b0);
`endif
            end else begin
                e_r0 = v0;
                e_r1 = v1;
            end
        end
        e_addr = e_r0 ? a0 : (e_r1 ? a1 : la_m);
        check_inst(0, 2, e_r0, e_r1, e_addr, if2.req0_ready, if2.req1_ready, if2.rom_address,
                   if2.busy, if2.rsp0_valid, if2.rsp0_data, if2.rsp1_valid, if2.rsp1_data);
        check_inst(1, 1, e_r0, e_r1, e_addr, if1.req0_ready, if1.req1_ready, if1.rom_address,
                   if1.busy, if1.rsp0_valid, if1.rsp0_data, if1.rsp1_valid, if1.rsp1_data);
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
            lg_m = 1'b1;
            la_m = '0;
            for (int i = 0; i < 2; i++) begin
                hold_m[i][0] = '0;
                hold_m[i][1] = '0;
            end
        end else if (e_r0 || e_r1) begin
            lg_m = e_r1;
            la_m = e_addr;
        end
    endtask

    task automatic sample();
        @(negedge clock);
        model_cycle();
        cyc_n++;
    endtask

    task automatic advance();
        @(posedge clock);
        #2;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    logic [7:0] exp_stream[8];
    int         idx;
    int         pulses;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc_n   = 0;
        lg_m    = 1'b1;
        la_m    = '0;
        for (int i = 0; i < 2; i++) begin
            hold_m[i][0] = '0;
            hold_m[i][1] = '0;
        end
        exp_stream = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        a0 = '0;
        a1 = '0;
        @(posedge clock);
        #2;

        // Reset state, with a request present that must not be granted
        v0 = 1'b1;
        a0 = 18'd9;
        sample();
        chk("reset req0_ready", 32'(if2.req0_ready), 32'd0);
        chk("reset rom_address", 32'(if2.rom_address), 32'd0);
        chk("reset busy", 32'(if2.busy), 32'd0);
        chk("reset rsp0_data", 32'(if2.rsp0_data), 32'd0);
        chk("reset rsp1_data", 32'(if2.rsp1_data), 32'd0);
        advance();
        reset = 1'b0;
        v0 = 1'b0;
        cyc();

        // Single read, port 0 address 0
        v0 = 1'b1;
        a0 = 18'd0;
        sample();
        chk("single req0_ready", 32'(if2.req0_ready), 32'd1);
        chk("single req1_ready", 32'(if2.req1_ready), 32'd0);
        advance();
        v0 = 1'b0;
        sample();
        chk("single L2 busy N+1", 32'(if2.busy), 32'd1);
        chk("single L2 early rsp0", 32'(if2.rsp0_valid), 32'd0);
        chk("single L1 rsp0_valid", 32'(if1.rsp0_valid), 32'd1);
        chk("single L1 rsp0_data", 32'(if1.rsp0_data), 32'hA5);
        advance();
        sample();
        chk("single L2 rsp0_valid", 32'(if2.rsp0_valid), 32'd1);
        chk("single L2 rsp0_data", 32'(if2.rsp0_data), 32'hA5);
        chk("single L2 busy N+2", 32'(if2.busy), 32'd1);
        chk("single L2 rsp1_valid", 32'(if2.rsp1_valid), 32'd0);
        advance();
        sample();
        chk("single L2 busy after", 32'(if2.busy), 32'd0);
        advance();

        // Back-to-back stream, port 1 addresses 0..7
        idx = 0;
        for (int a = 0; a < 11; a++) begin
            v1 = (a < 8);
            a1 = AW'(a < 8 ? a : 0);
            sample();
            if (if2.rsp1_valid) begin
                if (idx < 8) chk($sformatf("stream data %0d", idx), 32'(if2.rsp1_data),
                                 32'(exp_stream[idx]));
                idx++;
            end
            advance();
        end
        chk("stream pulse count", 32'(idx), 32'd8);

        // Contention: port 0 at address 1, port 1 at address 2
        v0 = 1'b1;
        a0 = 18'd1;
        v1 = 1'b1;
        a1 = 18'd2;
        for (int i = 0; i < 6; i++) begin
            sample();
`ifdef ROM_ARB_FIXED_PRIO_EN
            chk($sformatf("fixed grant0 %0d", i), 32'(if2.req0_ready), 32'd1);
            chk($sformatf("fixed grant1 %0d", i), 32'(if2.req1_ready), 32'd0);
`else
            chk($sformatf("rr grant0 %0d", i), 32'(if2.req0_ready), 32'(i % 2 == 0));
`endif
            advance();
        end
        v0 = 1'b0;
        sample();
        chk("port1 after port0 drops", 32'(if2.req1_ready), 32'd1);
        advance();
        v1 = 1'b0;
        repeat (3) cyc();
        chk("contention hold rsp0_data", 32'(if2.rsp0_data), 32'hA4);
        chk("contention hold rsp1_data", 32'(if2.rsp1_data), 32'hA7);

        // Reset mid-flight: accept port 0 address 3, then reset for two cycles
        v0 = 1'b1;
        a0 = 18'd3;
        sample();
        chk("midreset accept", 32'(if2.req0_ready), 32'd1);
        advance();
        v0 = 1'b0;
        reset = 1'b1;
        pulses = 0;
        sample();
        pulses += int'(if2.rsp0_valid) + int'(if1.rsp0_valid);
        advance();
        sample();
        pulses += int'(if2.rsp0_valid) + int'(if1.rsp0_valid);
        chk("midreset busy", 32'(if2.busy), 32'd0);
        chk("midreset rom_address", 32'(if2.rom_address), 32'd0);
        advance();
        reset = 1'b0;
        v1 = 1'b1;
        a1 = 18'd5;
        sample();
        pulses += int'(if2.rsp0_valid) + int'(if1.rsp0_valid);
        chk("accept as reset falls", 32'(if2.req1_ready), 32'd1);
        advance();
        v1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            pulses += int'(if2.rsp0_valid) + int'(if1.rsp0_valid);
            advance();
        end
        chk("midreset no rsp0 pulses", 32'(pulses), 32'd0);

        // Losing request withdrawn before it is accepted gets no response
        v0 = 1'b1;
        a0 = 18'd4;
        v1 = 1'b1;
        a1 = 18'd6;
        sample();
        chk("drop winner port0", 32'(if2.req0_ready), 32'd1);
        advance();
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (4) cyc();
        chk("drop hold rsp0_data", 32'(if2.rsp0_data), 32'hA1);
        chk("drop hold rsp1_data", 32'(if2.rsp1_data), 32'hA0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
